// File: rtl/chip8_rom_loader.sv
// Byte-stream ROM loader: writes an image into CHIP-8 memory port A from LOAD_BASE and holds
// the CPU in reset meanwhile. Optional read-back checksum verify under CHIP8_LOADER_VERIFY_EN.
module chip8_rom_loader #(
  parameter logic [11:0] LOAD_BASE = 12'h200,
  parameter int unsigned MAX_LEN   = 3584
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] length,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] byte_count
);

  localparam logic [11:0] MaxLenW = 12'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
`ifdef CHIP8_LOADER_VERIFY_EN
    StVerify,
    StCheck,
`endif
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [11:0] len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic        error_q, error_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        accept;
  logic        len_ok;

`ifdef CHIP8_LOADER_VERIFY_EN
  logic [11:0] rd_q, rd_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  vsum_q, vsum_d;
  logic [7:0]  vsum_final;
`else
  logic        unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      error_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef CHIP8_LOADER_VERIFY_EN
      rd_q      <= '0;
      rd_pend_q <= 1'b0;
      vsum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      error_q   <= error_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef CHIP8_LOADER_VERIFY_EN
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
      vsum_q    <= vsum_d;
`endif
    end
  end

  // Abort closes the stream in the same cycle so no byte is taken that would never be written.
  assign in_ready = (state_q == StLoad) && (count_q < len_q) && !abort;
  assign accept   = in_valid && in_ready;
  assign len_ok   = (length != 12'd0) && (length <= MaxLenW);

`ifdef CHIP8_LOADER_VERIFY_EN
  // The last read's data arrives during CHECK, so fold it in combinationally there.
  assign vsum_final = rd_pend_q ? vsum_q + mem_rdata : vsum_q;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    sum_d     = sum_q;
    error_d   = error_q;
    wr_en_d   = accept;
    wr_addr_d = accept ? LOAD_BASE + count_q : wr_addr_q;
    wr_data_d = accept ? in_data : wr_data_q;
`ifdef CHIP8_LOADER_VERIFY_EN
    rd_d      = rd_q;
    rd_pend_d = (state_q == StVerify);
    vsum_d    = vsum_final;
`endif

    if (accept) begin
      count_d = count_q + 12'd1;
      sum_d   = sum_q + in_data;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            len_d   = length;
            count_d = '0;
            sum_d   = '0;
            error_d = 1'b0;
`ifdef CHIP8_LOADER_VERIFY_EN
            rd_d    = '0;
            vsum_d  = '0;
`endif
            state_d = StLoad;
          end else begin
            error_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        if (abort) begin
          error_d = 1'b1;
          state_d = StDone;
        end else if (accept && (count_q == len_q - 12'd1)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (abort) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
`ifdef CHIP8_LOADER_VERIFY_EN
          state_d = StVerify;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CHIP8_LOADER_VERIFY_EN
      StVerify: begin
        if (abort) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          rd_d = rd_q + 12'd1;
          if (rd_q == len_q - 12'd1) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (vsum_final != sum_q) begin
          error_d = 1'b1;
        end
        state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mem_en    = wr_en_q;
    mem_write = wr_en_q;
    mem_addr  = wr_addr_q;
    mem_wdata = wr_data_q;
`ifdef CHIP8_LOADER_VERIFY_EN
    if (state_q == StVerify) begin
      mem_en    = 1'b1;
      mem_write = 1'b0;
      mem_addr  = LOAD_BASE + rd_q;
    end
`endif
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign cpu_hold   = busy && !done;
  assign error      = error_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Self-checking bench for chip8_rom_loader: table of load scenarios, randomized loads against
// an expected write list, plus hand sequences for start-while-busy and reset mid-load.
module tb_chip8_rom_loader;

  localparam logic [11:0] LOAD_BASE = 12'h200;
  localparam int MAX_LEN = 3584;

  logic        clk, rst_n, start, abort, in_valid, in_ready;
  logic [11:0] length, mem_addr, byte_count;
  logic [7:0]  in_data, mem_wdata, mem_rdata;
  logic        mem_en, mem_write, cpu_hold, busy, done, error;

  chip8_rom_loader #(.LOAD_BASE(LOAD_BASE), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with an access log; corrupt flips the byte stored at 0x202.
  typedef struct {
    int          cyc;
    bit          we;
    logic [11:0] addr;
    logic [7:0]  data;
  } acc_t;

  logic [7:0] mem [4096];
  acc_t       log_q[$];
  int         cyc = 0;
  bit         corrupt = 0;

  always @(posedge clk) begin
    acc_t a;
    if (mem_en) begin
      a.cyc = cyc; a.we = mem_write; a.addr = mem_addr; a.data = mem_wdata;
      log_q.push_back(a);
      if (mem_write) mem[mem_addr] <= (corrupt && mem_addr == 12'h202) ? ~mem_wdata : mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
    cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_writes();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].we) n++;
    return n;
  endfunction

  // Runs one load; starts and ends at posedge+1 with the DUT idle.
  // mode: 0 valid always, 1 valid every other cycle, 2 random valid. abort_at<0: no abort.
  task automatic run_load(input string nm, input int len, input int mode, input int abort_at,
                          input bit fixed, input bit exp_err, input int exp_cnt);
    logic [7:0] d[$];
    int         exp_cyc[$];
    int         cnt = 0;
    int         budget = 0;
    int         limit;
    int         wi;
    bit         aborted = 0;
    bit         ok_len;
    ok_len = (len >= 1) && (len <= MAX_LEN);
    limit = len * 20 + 100;
    if (fixed) d = '{8'h12, 8'h34, 8'h56, 8'h78};
    else if (ok_len) for (int i = 0; i < len; i++) d.push_back(8'($urandom));
    log_q.delete();

    start = 1'b1; length = 12'(len);
    #3;
    chk({nm, "_idle_busy"}, busy, 0);
    next_cycle();
    start = 1'b0;

    if (!ok_len) begin
      #3;
      chk({nm, "_done"}, done, 1);
      chk({nm, "_error"}, error, 1);
      chk({nm, "_hold"}, cpu_hold, 0);
      chk({nm, "_mem_en"}, mem_en, 0);
      next_cycle();
      #3;
      chk({nm, "_idle_after"}, busy, 0);
      chk({nm, "_no_access"}, log_q.size(), 0);
      next_cycle();
      return;
    end

    while (cnt < len && !aborted && budget < limit) begin
      if (abort_at >= 0 && cnt == abort_at) begin
        abort = 1'b1; in_valid = 1'b0; aborted = 1;
      end else begin
        in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : ($urandom_range(0, 9) < 6);
        in_data = d[cnt];
      end
      #3;
      chk({nm, "_load_hold"}, cpu_hold, 1);
      chk({nm, "_load_done"}, done, 0);
      if (!aborted) chk({nm, "_ready"}, in_ready, 1);
      if (in_valid && !aborted) begin
        exp_cyc.push_back(cyc + 1);
        cnt++;
      end
      budget++;
      next_cycle();
      abort = 1'b0; in_valid = 1'b0;
    end
    if (budget >= limit) chk({nm, "_budget"}, budget, 0);

    if (!aborted) begin
      #3;
      chk({nm, "_flush_hold"}, cpu_hold, 1);
      chk({nm, "_flush_ready"}, in_ready, 0);
      chk({nm, "_flush_write"}, {mem_en, mem_write}, 2'b11);
      next_cycle();
`ifdef CHIP8_LOADER_VERIFY_EN
      for (int i = 0; i < len; i++) begin
        #3;
        chk({nm, "_rd_en"}, {mem_en, mem_write, cpu_hold}, 3'b101);
        chk({nm, "_rd_addr"}, mem_addr, LOAD_BASE + 12'(i));
        next_cycle();
      end
      #3;
      chk({nm, "_check_hold"}, {cpu_hold, done}, 2'b10);
      next_cycle();
`endif
    end

    #3;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_error"}, error, exp_err);
    chk({nm, "_done_hold"}, cpu_hold, 0);
    chk({nm, "_done_ready"}, in_ready, 0);
    chk({nm, "_count"}, byte_count, exp_cnt);
    next_cycle();
    #3;
    chk({nm, "_idle"}, {busy, done}, 2'b00);
    chk({nm, "_err_sticky"}, error, exp_err);
    chk({nm, "_count_hold"}, byte_count, exp_cnt);

    chk({nm, "_nwrites"}, count_writes(), cnt);
    wi = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we && wi < cnt) begin
        chk({nm, "_waddr"}, log_q[i].addr, LOAD_BASE + 12'(wi));
        chk({nm, "_wdata"}, log_q[i].data, d[wi]);
        chk({nm, "_wcyc"}, log_q[i].cyc, exp_cyc[wi]);
        wi++;
      end
    end
    next_cycle();
  endtask

  typedef struct {
    string nm;
    int    len;
    int    mode;
    int    abort_at;
    bit    fixed;
    bit    exp_err;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[10];
  bit   found;

  initial begin
    vecs[0] = '{"load4",      4,    0, -1, 1, 0, 4};
    vecs[1] = '{"len0",       0,    0, -1, 0, 1, 0};
    vecs[2] = '{"reload4",    4,    0, -1, 1, 0, 4};
    vecs[3] = '{"len3585",    3585, 0, -1, 0, 1, 0};
    vecs[4] = '{"toggle4",    4,    1, -1, 1, 0, 4};
    vecs[5] = '{"abort5",     16,   0, 5,  0, 1, 5};
    vecs[6] = '{"len1",       1,    0, -1, 0, 0, 1};
    vecs[7] = '{"len4095",    4095, 0, -1, 0, 1, 0};
    vecs[8] = '{"lenmax",     3584, 0, -1, 0, 0, 3584};
    vecs[9] = '{"abort0",     8,    2, 0,  0, 1, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; length = '0; in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_outputs", {in_ready, mem_en, mem_write, cpu_hold, busy, done, error}, 0);
    chk("rst_bus", {mem_addr, mem_wdata, byte_count}, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    foreach (vecs[i])
      run_load(vecs[i].nm, vecs[i].len, vecs[i].mode, vecs[i].abort_at, vecs[i].fixed,
               vecs[i].exp_err, vecs[i].exp_cnt);

    for (int r = 0; r < 15; r++) begin
      int len;
      int ab;
      len = int'($urandom_range(1, 40));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_load("rand", len, 2, ab, 0, ab >= 0, (ab >= 0) ? ab : len);
    end

    // start pulsed mid-load must not restart or shorten the load
    log_q.delete();
    start = 1'b1; length = 12'd6;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i);
      next_cycle();
    end
    in_valid = 1'b0; start = 1'b1; length = 12'd2;
    #3;
    chk("startign_busy", busy, 1);
    next_cycle();
    start = 1'b0;
    for (int i = 2; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i);
      #3;
      chk("startign_ready", in_ready, 1);
      next_cycle();
    end
    in_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      #3;
      if (done) found = 1;
      else next_cycle();
    end
    chk("startign_done_seen", found, 1);
    chk("startign_count", byte_count, 6);
    chk("startign_error", error, 0);
    chk("startign_writes", count_writes(), 6);
    next_cycle();

    // asynchronous reset in the middle of a load
    start = 1'b1; length = 12'd8;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      next_cycle();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {in_ready, mem_en, mem_write, cpu_hold, busy, done, error}, 0);
    chk("midrst_bus", {mem_addr, mem_wdata, byte_count}, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    run_load("post_rst", 4, 0, -1, 1, 0, 4);

`ifdef CHIP8_LOADER_VERIFY_EN
    corrupt = 1;
    run_load("verify_bad", 4, 0, -1, 1, 1, 4);
    corrupt = 0;
    run_load("verify_ok", 4, 0, -1, 1, 0, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
